// File: rtl/flash_loader.sv
// Loads a length-prefixed byte stream into instruction flash as little-endian words from address 0,
// holding the core in reset until a clean load. Define FLASH_LOADER_CHECKSUM_EN for an XOR trailer.
module flash_loader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  flash_en,
  output logic [ADDR_WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0]      flash_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StError} state_e;

`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam state_e StAfterData = StCsum;
`else
  localparam state_e StAfterData = StDone;
`endif

  state_e              state;
  logic [15:0]         len;
  logic [ADDR_WIDTH:0] word_cnt;
  logic [IDX_W-1:0]    byte_idx;
  logic [WIDTH-1:0]    word;
  logic [WIDTH-1:0]    word_next;
  logic [15:0]         len_next;
  logic                xfer;
  logic                last_lane;
  logic                last_word;
  logic                can_start;
`ifdef FLASH_LOADER_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  // Status outputs are pure decodes of the state register.
  assign byte_ready = state inside {StLenLo, StLenHi, StData, StCsum};
  assign busy       = byte_ready;
  assign done       = (state == StDone);
  assign err        = (state == StError);
  assign cpu_rst    = (state != StDone);

  assign xfer      = byte_valid && byte_ready;
  assign last_lane = (32'(byte_idx) == BYTES - 1);
  assign last_word = ((32'(word_cnt) + 32'd1) == 32'(len));
  assign len_next  = {byte_data, len[7:0]};
  assign can_start = start && (state inside {StIdle, StDone, StError});

  always_comb begin
    word_next = word;
    word_next[8*32'(byte_idx) +: 8] = byte_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      len        <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word       <= '0;
      flash_en   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      flash_en <= 1'b0;
      if (can_start) begin
        state    <= StLenLo;
        word_cnt <= '0;
        byte_idx <= '0;
        word     <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end else if (xfer) begin
        unique case (state)
          StLenLo: begin
            len[7:0] <= byte_data;
            state    <= StLenHi;
          end
          StLenHi: begin
            len[15:8] <= byte_data;
            if (32'(len_next) > DEPTH) begin
              state <= StError;
            end else if (len_next == 16'd0) begin
              state <= StAfterData;
            end else begin
              state <= StData;
            end
          end
          StData: begin
            word <= word_next;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (last_lane) begin
              // Write strobe lands one cycle after the word's final byte.
              byte_idx   <= '0;
              flash_en   <= 1'b1;
              flash_addr <= word_cnt[ADDR_WIDTH-1:0];
              flash_data <= word_next;
              word_cnt   <= word_cnt + 1'b1;
              if (last_word) begin
                state <= StAfterData;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
`ifdef FLASH_LOADER_CHECKSUM_EN
          StCsum: begin
            state <= (byte_data == csum) ? StDone : StError;
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: fixed frames, a vector table and random frames
// checked against a byte-list reference model.
module tb_flash_loader;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 11;
  localparam int unsigned BYTES      = WIDTH / 8;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
`ifdef FLASH_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = 8'h00;
  logic                  byte_ready;
  logic                  flash_en;
  logic [ADDR_WIDTH-1:0] flash_addr;
  logic [WIDTH-1:0]      flash_data;
  logic                  cpu_rst;
  logic                  busy;
  logic                  done;
  logic                  err;

  int checks = 0;
  int errors = 0;

  flash_loader #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .flash_en  (flash_en),
    .flash_addr(flash_addr),
    .flash_data(flash_data),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } wr_t;
  wr_t  wr_q[$];
  logic xfer_prev = 1'b0;
  logic en_prev   = 1'b0;

  // Write capture: every strobe must follow a byte transfer and last a single cycle.
  always @(negedge clk) begin
    #1;
    if (flash_en === 1'b1) begin
      wr_q.push_back('{flash_addr, flash_data});
      check("write_latency", {63'd0, xfer_prev}, 64'd1);
      check("strobe_width", {63'd0, en_prev}, 64'd0);
    end
    xfer_prev <= byte_valid && byte_ready;
    en_prev   <= flash_en;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the byte was taken plus the gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries = 0;
    int g;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && tries < 40) begin
      @(negedge clk);
      tries++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: byte 0x%0h byte_ready=%b expected 1", b, byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) @(negedge clk);
  endtask

  task automatic settle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL settle: busy=%b expected 0 after %0d cycles", busy, t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input bit exp_ok);
    check({tag, "_done"}, done, exp_ok);
    check({tag, "_err"}, err, !exp_ok);
    check({tag, "_cpu_rst"}, cpu_rst, !exp_ok);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_byte_ready"}, byte_ready, 0);
  endtask

  task automatic two_word(input int gap, input bit poke, input logic [7:0] cs, input bit exp_ok);
    logic [7:0] tw[10];
    tw = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(tw[i], gap);
      if (poke && i == 5) pulse_start();
    end
    if (CSUM) send_byte(cs, gap);
    settle();
    check("tw_count", wr_q.size(), 2);
    if (wr_q.size() >= 2) begin
      check("tw_addr0", wr_q[0].addr, 0);
      check("tw_data0", wr_q[0].data, 32'h0050_0013);
      check("tw_addr1", wr_q[1].addr, 1);
      check("tw_data1", wr_q[1].data, 32'h0010_0093);
    end
    check_status("tw", exp_ok);
  endtask

  task automatic run_load(input int n, input int gap, input bit bad, input int exp_writes,
                          input bit exp_done);
    logic [7:0]       dq[$];
    logic [7:0]       x = 8'h00;
    logic [15:0]      nn;
    logic [WIDTH-1:0] w;
    nn = 16'(n);
    wr_q.delete();
    pulse_start();
    send_byte(nn[7:0], gap);
    send_byte(nn[15:8], gap);
    if (n <= DEPTH) begin
      for (int i = 0; i < n * BYTES; i++) begin
        dq.push_back(8'($urandom));
        x ^= dq[i];
        send_byte(dq[i], gap);
      end
      if (CSUM) send_byte(x ^ {7'd0, bad}, gap);
    end
    settle();
    check("load_count", wr_q.size(), exp_writes);
    for (int i = 0; i < wr_q.size() && i < exp_writes; i++) begin
      w = '0;
      for (int k = 0; k < BYTES; k++) w |= WIDTH'(dq[i*BYTES+k]) << (8 * k);
      check("load_addr", wr_q[i].addr, i);
      check("load_data", wr_q[i].data, w);
    end
    if (exp_writes == DEPTH && wr_q.size() == DEPTH) check("last_addr", wr_q[DEPTH-1].addr, 'h7FF);
    check_status("load", exp_done);
  endtask

  typedef struct {
    int n;
    int gap;
    bit bad;
    int exp_writes;
    bit exp_done;
  } vec_t;

  initial begin
    vec_t vecs[7];
    vecs[0] = '{0, 0, 1'b0, 0, 1'b1};
    vecs[1] = '{1, 0, 1'b0, 1, 1'b1};
    vecs[2] = '{3, 2, 1'b0, 3, 1'b1};
    vecs[3] = '{2049, 0, 1'b0, 0, 1'b0};
    vecs[4] = '{4, -1, 1'b1, 4, !CSUM};
    vecs[5] = '{2048, 0, 1'b0, 2048, 1'b1};
    vecs[6] = '{5, 1, 1'b0, 5, 1'b1};

    // Reset and idle behaviour.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_flash_en", flash_en, 0);
    check("rst_flash_addr", flash_addr, 0);
    check("rst_flash_data", flash_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("idle_byte_ready", byte_ready, 0);
    check("idle_no_write", wr_q.size(), 0);
    byte_valid = 1'b0;

    // Fixed two-word frame, back-to-back then gapped with a start pulse mid-load.
    two_word(0, 1'b0, 8'hC0, 1'b1);
    two_word(3, 1'b1, 8'hC0, 1'b1);
    two_word(0, 1'b0, 8'hC1, !CSUM);

    // Restart from a finished load raises cpu_rst the cycle after start.
    wr_q.delete();
    pulse_start();
    check("restart_cpu_rst", cpu_rst, 1);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    if (CSUM) send_byte(8'h00, 0);
    settle();
    check("restart_n0_count", wr_q.size(), 0);
    check_status("restart", 1'b1);

    // Reset in the middle of a word discards it.
    wr_q.delete();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_count", wr_q.size(), 0);
    check("midrst_addr", flash_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_done", done, 0);
    two_word(0, 1'b0, 8'hC0, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].n, vecs[i].gap, vecs[i].bad, vecs[i].exp_writes, vecs[i].exp_done);
    end

    for (int r = 0; r < 6; r++) begin
      int n;
      bit bad;
      n   = int'($urandom_range(0, 8));
      bad = 1'($urandom_range(0, 1));
      run_load(n, -1, bad, n, !(CSUM && bad));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
